laser_tx_arbiter: RTL
=====================

# laser_tx_arbiter

Shares the single serial laser transmitter (`serial_tx`, 288-bit packets) between two requesters: the data packet generator (go-back-n window traffic) and the bare-ACK/control generator. Grants one packet at a time, drives the transmitter's load strobe and enforces an inter-packet guard gap. Runs a retransmission timer for data packets that tells the main state machine to rewind its window. Sits between `makepacket`/ACK logic and `serial_tx` in the top level.

## Interface
- `PKT_W`, 288, packet width in bits (32*9)
- `GAP_CYCLES`, 1000, idle guard cycles after every `tx_done`; 0 allowed
- `TIMEOUT_CYCLES`, 40_000_000, retransmit timeout in clocks, ≥1
- `TIMER_W`, 32, timer width; must hold `TIMEOUT_CYCLES`

- `clk` in 1: system clock (65 MHz)
- `reset_n` in 1: asynchronous, active-low reset
- `data_req` in 1: data requester has a packet; level, held until `data_gnt`
- `data_pkt` in PKT_W: data packet, stable while `data_req`
- `data_gnt` out 1: one-cycle pulse, data packet captured
- `ack_req` in 1: ACK requester has a packet; level, held until `ack_gnt`
- `ack_pkt` in PKT_W: ACK packet, stable while `ack_req`
- `ack_gnt` out 1: one-cycle pulse, ACK packet captured
- `tx_data` out PKT_W: packet to `serial_tx.data`
- `tx_new_data` out 1: one-cycle load strobe to `serial_tx.new_data`
- `tx_done` in 1: one-cycle pulse from `serial_tx` at end of packet
- `window_acked` in 1: pulse from main FSM, all outstanding data acknowledged
- `timeout` out 1: one-cycle pulse, retransmit timer expired
- `retx_count` out 8: saturating count of `timeout` pulses
- `state` out 2: current state for 7-segment debug

## Operation
- States: IDLE(0), SEND(1), GAP(2).
- IDLE: if any req, select winner, assert its gnt and `tx_new_data`, load `tx_data` with winner's packet, go SEND — all in the same registered update.
- Arbitration: round-robin on a `last_was_ack` bit. Only one req → it wins. Both → the one not served last wins. Reset value of `last_was_ack` = 0, so first contention goes to ACK.
- SEND: wait for `tx_done`. Requests ignored. On `tx_done`: GAP if `GAP_CYCLES`>0 (gap counter loaded with `GAP_CYCLES-1`), else IDLE.
- GAP: decrement counter; at 0 go IDLE. No grants in GAP.
- `tx_data` holds last granted packet until the next grant.
- Retransmit timer: armed on `tx_done` ending a data packet (tracked by `last_was_ack`=0); counts up from 0 each clock while armed; on reaching `TIMEOUT_CYCLES-1` pulses `timeout`, disarms, clears. `window_acked` disarms and clears immediately. Re-arming on a later data `tx_done` restarts from 0. ACK `tx_done` does not touch the timer.
- Same-cycle `window_acked` and expiry: `window_acked` wins, no `timeout`.
- Same-cycle `window_acked` and arming `tx_done`: timer arms from 0.
- `retx_count` increments on each `timeout`, saturates at 255.

## Timing
- Reset (async assert, sync use on deassert): state IDLE, `tx_data`=0, all pulses 0, `retx_count`=0, timer disarmed/0, `last_was_ack`=0.
- Grant latency: req seen high at edge N → gnt, `tx_new_data`, `tx_data` valid after edge N+1 (one cycle).
- Requester must deassert req the cycle after gnt; a req still high in IDLE after GAP is treated as a new packet.
- `tx_done` → next grant earliest `GAP_CYCLES+1` cycles later.
- `timeout` asserts exactly `TIMEOUT_CYCLES` clocks after the arming `tx_done`.
- `tx_done` while in IDLE or GAP: ignored for state; still ignored for timer.
- Reset mid-SEND: drops to IDLE; no `tx_new_data` glitch.

## Configuration
- `LASER_TX_RETX_TIMER_EN` defined: retransmit timer, `timeout`, `retx_count` as above.
- Not defined: timer logic removed; `timeout` tied 0, `retx_count` tied 0; `window_acked` unused. Arbitration and gap unchanged.

## Structure
- Shared package `lasernet_pkg`: `PKT_W` constant, state enum (IDLE/SEND/GAP), default `GAP_CYCLES`/`TIMEOUT_CYCLES`.
- One sub-module: `retx_timer` (arm/clear/expire counter, `TIMER_W`, `TIMEOUT_CYCLES`), instantiated only under the macro.

## Test plan
- GAP_CYCLES=4: `data_req` only with pkt=288'hA5… → `data_gnt`+`tx_new_data` 1 cycle later, `tx_data`=pkt; `tx_done` → next grant no sooner than 5 cycles later.
- Both reqs high from reset → ACK first, then data after gap; repeated contention alternates ACK/data/ACK.
- TIMEOUT_CYCLES=100: data sent, `tx_done`, no ack → `timeout` exactly 100 cycles later, `retx_count`=1.
- Same, `window_acked` at cycle 50 → no `timeout`; `window_acked` on expiry cycle → no `timeout`.
- ACK-only traffic with `tx_done` → timer never arms, `timeout` stays 0.
- `reset_n` low mid-SEND and mid-GAP → all outputs at reset values immediately; first req afterwards granted in 1 cycle.

Source files
------------

// File: rtl/lasernet_pkg.sv
// lasernet_pkg: shared constants and types for the laser link datapath.
// Holds the packet width, arbiter state encoding and default timings.
package lasernet_pkg;

   localparam int PKT_W              = 288;
   localparam int GAP_CYCLES_DEF     = 1000;
   localparam int TIMEOUT_CYCLES_DEF = 40_000_000;
   localparam int TIMER_W_DEF        = 32;

   typedef logic [PKT_W-1:0] pkt_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/laser_tx_arbiter_if.sv
// laser_tx_arbiter_if: requester and serial_tx side signals of the arbiter.
// master = requesters/serial_tx (testbench side), slave = the arbiter.
interface laser_tx_arbiter_if;
   import lasernet_pkg::*;

   logic data_req;
   pkt_t data_pkt;
   logic data_gnt;
   logic ack_req;
   pkt_t ack_pkt;
   logic ack_gnt;
   pkt_t tx_data;
   logic tx_new_data;
   logic tx_done;

   modport master (
      output data_req, data_pkt, ack_req, ack_pkt, tx_done,
      input  data_gnt, ack_gnt, tx_data, tx_new_data
   );

   modport slave (
      input  data_req, data_pkt, ack_req, ack_pkt, tx_done,
      output data_gnt, ack_gnt, tx_data, tx_new_data
   );

endinterface

// File: rtl/laser_tx_arbiter_retx_timer.sv
// retx_timer: retransmit timer; arm restarts from 0, clear disarms,
// expiry pulses timeout and bumps a saturating 8-bit retx_count.
module retx_timer #(
   parameter int TIMER_W        = 32,
   parameter int TIMEOUT_CYCLES = 40_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       arm,
   input  logic       clear,
   output logic       timeout,
   output logic [7:0] retx_count
);

   localparam logic [TIMER_W-1:0] LAST =
      TIMER_W'(TIMEOUT_CYCLES - 1);

   logic               armed_q;
   logic [TIMER_W-1:0] cnt_q;

   // arm beats clear (restart from 0); clear beats expiry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         armed_q    <= 1'b0;
         cnt_q      <= '0;
         timeout    <= 1'b0;
         retx_count <= '0;
      end else begin
         timeout <= 1'b0;
         if (arm) begin
            armed_q <= 1'b1;
            cnt_q   <= '0;
         end else if (clear) begin
            armed_q <= 1'b0;
            cnt_q   <= '0;
         end else if (armed_q) begin
            if (cnt_q == LAST) begin
               armed_q <= 1'b0;
               cnt_q   <= '0;
               timeout <= 1'b1;
               if (retx_count != 8'hFF)
                  retx_count <= retx_count + 8'd1;
            end else begin
               cnt_q <= cnt_q + TIMER_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/laser_tx_arbiter.sv
// laser_tx_arbiter: shares serial_tx between data and ACK requesters.
// Ports: clk, reset_n, bus (req/pkt/gnt + tx_data/tx_new_data/tx_done),
// window_acked, timeout, retx_count, state. Timer: LASER_TX_RETX_TIMER_EN.
module laser_tx_arbiter
   import lasernet_pkg::*;
#(
   parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int TIMER_W        = TIMER_W_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   laser_tx_arbiter_if.slave  bus,
   input  logic               window_acked,
   output logic               timeout,
   output logic [7:0]         retx_count,
   output logic [1:0]         state
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_t           state_q, state_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             last_ack_q, last_ack_d;
   pkt_t             tx_data_q, tx_data_d;
   logic             dgnt_q, dgnt_d;
   logic             agnt_q, agnt_d;
   logic             new_q, new_d;
   logic             any_req;
   logic             pick_ack;

   // ACK wins unless data also wants the line and ACK went last
   assign any_req  = bus.data_req | bus.ack_req;
   assign pick_ack = bus.ack_req & (~bus.data_req | ~last_ack_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         gap_q      <= '0;
         last_ack_q <= 1'b0;
         tx_data_q  <= '0;
         dgnt_q     <= 1'b0;
         agnt_q     <= 1'b0;
         new_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         last_ack_q <= last_ack_d;
         tx_data_q  <= tx_data_d;
         dgnt_q     <= dgnt_d;
         agnt_q     <= agnt_d;
         new_q      <= new_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      last_ack_d = last_ack_q;
      tx_data_d  = tx_data_q;
      dgnt_d     = 1'b0;
      agnt_d     = 1'b0;
      new_d      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               new_d      = 1'b1;
               agnt_d     = pick_ack;
               dgnt_d     = ~pick_ack;
               last_ack_d = pick_ack;
               tx_data_d  = pick_ack ? bus.ack_pkt
                                     : bus.data_pkt;
               state_d    = ST_SEND;
            end
         end
         ST_SEND: begin
            if (bus.tx_done) begin
               if (GAP_CYCLES > 0) begin
                  state_d = ST_GAP;
                  gap_d   = GAP_W'(GAP_CYCLES - 1);
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_q == '0)
               state_d = ST_IDLE;
            else
               gap_d = gap_q - GAP_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.tx_data     = tx_data_q;
   assign bus.tx_new_data = new_q;
   assign bus.data_gnt    = dgnt_q;
   assign bus.ack_gnt     = agnt_q;
   assign state           = state_q;

`ifdef LASER_TX_RETX_TIMER_EN
   // last_ack_q still names the packet on the line during SEND
   logic data_done;
   assign data_done = (state_q == ST_SEND) & bus.tx_done
                      & ~last_ack_q;

   retx_timer #(
      .TIMER_W        (TIMER_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_retx_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .arm        (data_done),
      .clear      (window_acked),
      .timeout    (timeout),
      .retx_count (retx_count)
   );
`else
   logic               unused_wa;
   logic [TIMER_W-1:0] unused_cfg;
   assign unused_wa  = window_acked;
   assign unused_cfg = TIMER_W'(TIMEOUT_CYCLES);
   assign timeout    = 1'b0;
   assign retx_count = '0;
`endif

endmodule
